y_demux4_dispatch: RTL and testbench

//  Registered 1-to-4 demultiplexer: inverse of the 4-to-1 mux. One SIZE-bit input stream is

---
 rtl/y_demux4_dispatch_pkg.sv | 27 ++
 rtl/y_lane_buf.sv | 43 ++++
 rtl/y_demux4_dispatch.sv | 89 ++++++++
 tb/tb_y_demux4_dispatch.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/y_demux4_dispatch_pkg.sv
// Shared lane constants and helpers for the 1-to-4 dispatcher.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
//
// Contents: lane count and lane index width, the lane index type, and
// helpers for one-hot lane decode and round-robin pointer advance.
package y_demux4_dispatch_pkg;

    localparam int Y_LANES  = 4;
    localparam int Y_LANE_W = 2;

    typedef logic [Y_LANE_W-1:0] lane_t;

    // One-hot decode of a lane index: bit i set when lane == i.
    function automatic logic [Y_LANES-1:0] lane_onehot(input lane_t lane);
        logic [Y_LANES-1:0] oh;
        oh       = '0;
        oh[lane] = 1'b1;
        return oh;
    endfunction

    // Round-robin successor; the index width makes 3 wrap back to 0.
    function automatic lane_t lane_next(input lane_t lane);
        return lane + lane_t'(1);
    endfunction

endpackage

// File: rtl/y_lane_buf.sv
// One-entry register slice holding a single beat for one output lane.
// Latency: a beat loaded at edge N is on q/valid after edge N.
// Backpressure: free when empty or draining this cycle, so load and drain can coincide.
//
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   load        write data into the slot this cycle (caller guarantees free=1)
//   data        beat to store
//   valid       slot holds an undelivered beat
//   ready       downstream consumer takes the beat this cycle
//   free        slot can accept a beat this cycle
//   q           stored beat (held after drain, cleared only by reset)
module y_lane_buf #(
    parameter int SIZE = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [SIZE-1:0] data,
    output logic            valid,
    input  logic            ready,
    output logic            free,
    output logic [SIZE-1:0] q
);

    // A full slot whose consumer is taking the beat now counts as free,
    // letting the producer refill it on the same edge.
    assign free = ~valid | ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= data;
        end else if (valid && ready) begin
            // Drained with no refill: drop valid, keep the data visible.
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/y_demux4_dispatch.sv
// Registered 1-to-4 demux: routes one input stream to a lane chosen by sel or a round-robin pointer.
// Latency: one cycle from accept to the beat appearing on z<L>/out_valid[L].
// Backpressure: in_ready follows only the target lane, so a stalled lane never blocks the others.
//
// Ports:
//   clk, rst_n           clock and synchronous active-low reset
//   rr_mode, sel         lane choice: rr_mode=1 uses rr_ptr, else sel
//   in_valid/in_ready    input handshake, in_data the beat
//   z0..z3               registered lane data
//   out_valid/out_ready  per-lane handshake, bit i = lane i
//   rr_ptr               round-robin pointer
//   beat_cnt             accepted-beat counter, wraps modulo 2^CNT_W
module y_demux4_dispatch
    import y_demux4_dispatch_pkg::*;
#(
    parameter int SIZE  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rr_mode,
    input  logic [1:0]       sel,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SIZE-1:0]  in_data,
    output logic [SIZE-1:0]  z0,
    output logic [SIZE-1:0]  z1,
    output logic [SIZE-1:0]  z2,
    output logic [SIZE-1:0]  z3,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [1:0]       rr_ptr,
    output logic [CNT_W-1:0] beat_cnt
);

    lane_t               lane;
    logic                accept;
    logic [Y_LANES-1:0]  lane_free;
    logic [Y_LANES-1:0]  lane_load;
    logic [SIZE-1:0]     lane_q [Y_LANES];

    // Target lane is purely combinational; a mode change is therefore seen
    // by the very next handshake while rr_ptr keeps its value.
    assign lane = rr_mode ? lane_t'(rr_ptr) : lane_t'(sel);

    // Gate with rst_n so nothing is offered as accepted during reset.
    assign in_ready  = rst_n & lane_free[lane];
    assign accept    = in_valid & in_ready;
    assign lane_load = accept ? lane_onehot(lane) : '0;

    for (genvar i = 0; i < Y_LANES; i++) begin : g_lane
        y_lane_buf #(
            .SIZE (SIZE)
        ) u_buf (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (lane_load[i]),
            .data  (in_data),
            .valid (out_valid[i]),
            .ready (out_ready[i]),
            .free  (lane_free[i]),
            .q     (lane_q[i])
        );
    end

    assign z0 = lane_q[0];
    assign z1 = lane_q[1];
    assign z2 = lane_q[2];
    assign z3 = lane_q[3];

    // The pointer moves only on an accepted beat in round-robin mode, so a
    // stalled target lane holds it in place (strict order, no skipping).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (accept && rr_mode) begin
            rr_ptr <= lane_next(rr_ptr);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (accept) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_y_demux4_dispatch.sv
module tb_y_demux4_dispatch;

    localparam int SIZE  = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             rr_mode;
    logic [1:0]       sel;
    logic             in_valid;
    logic             in_ready;
    logic [SIZE-1:0]  in_data;
    logic [SIZE-1:0]  z0, z1, z2, z3;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [1:0]       rr_ptr;
    logic [CNT_W-1:0] beat_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    y_demux4_dispatch #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rr_mode   (rr_mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .z0        (z0),
        .z1        (z1),
        .z2        (z2),
        .z3        (z3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rr_ptr    (rr_ptr),
        .beat_cnt  (beat_cnt)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: each lane is a queue of pending beats (at most one),
    // plus the last beat written to it; pointer and counter are integers.
    logic [31:0] m_pend [4][$];
    logic [31:0] m_last [4];
    int          m_ptr = 0;
    int          m_cnt = 0;
    int          m_acc = 0;

    initial begin
        for (int i = 0; i < 4; i++) m_last[i] = '0;
    end

    function automatic logic [31:0] dut_z(input int i);
        case (i)
            0:       return z0;
            1:       return z1;
            2:       return z2;
            default: return z3;
        endcase
    endfunction

    // Monitor/scoreboard: compares DUT state against the model mid-cycle,
    // then advances the model by what the coming edge must do.
    always @(negedge clk) begin
        int          tgt;
        logic        exp_rdy;
        logic [31:0] got;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("out_valid[%0d]", i), {31'b0, out_valid[i]},
                {31'b0, m_pend[i].size() != 0});
            chk($sformatf("z%0d", i), dut_z(i), m_last[i]);
        end
        chk("rr_ptr", {30'b0, rr_ptr}, m_ptr);
        chk("beat_cnt", {28'b0, beat_cnt}, m_cnt);
        tgt     = rr_mode ? m_ptr : int'(sel);
        exp_rdy = rst_n && (m_pend[tgt].size() == 0 || out_ready[tgt]);
        chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});

        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                m_pend[i].delete();
                m_last[i] = '0;
            end
            m_ptr = 0;
            m_cnt = 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (m_pend[i].size() != 0 && out_ready[i]) begin
                    got = dut_z(i);
                    chk($sformatf("drain lane%0d", i), got, m_pend[i].pop_front());
                end
            end
            if (in_valid && exp_rdy) begin
                m_pend[tgt].push_back(in_data);
                m_last[tgt] = in_data;
                if (rr_mode) m_ptr = (m_ptr + 1) % 4;
                m_cnt = (m_cnt + 1) % (1 << CNT_W);
                m_acc++;
            end
        end
    end

    task automatic set_in(input logic v, input logic mode, input logic [1:0] s,
                          input logic [31:0] d, input logic [3:0] rdy);
        in_valid  = v;
        rr_mode   = mode;
        sel       = s;
        in_data   = d;
        out_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(1'b1, 1'b0, 2'd0, 32'hDEAD, 4'hF);

        // Reset held two cycles with in_valid asserted.
        tick();
        tick();
        chk("reset in_ready", {31'b0, in_ready}, 32'd0);
        chk("reset out_valid", {28'b0, out_valid}, 32'd0);
        chk("reset rr_ptr", {30'b0, rr_ptr}, 32'd0);
        chk("reset beat_cnt", {28'b0, beat_cnt}, 32'd0);
        rst_n = 1'b1;
        set_in(1'b0, 1'b0, 2'd0, 32'h0, 4'hF);
        tick();

        // Select mode, one beat per lane.
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 1'b0, 2'(i), 32'hA0 + 32'(i), 4'hF);
            tick();
        end
        set_in(1'b0, 1'b0, 2'd0, 32'h0, 4'hF);
        chk("sel z0", z0, 32'hA0);
        chk("sel z1", z1, 32'hA1);
        chk("sel z2", z2, 32'hA2);
        chk("sel z3", z3, 32'hA3);
        chk("sel beat_cnt", {28'b0, beat_cnt}, 32'd4);
        tick();

        // Backpressure on lane 2, then drain+refill in the same cycle.
        set_in(1'b1, 1'b0, 2'd2, 32'h11, 4'b1011);
        tick();
        set_in(1'b1, 1'b0, 2'd2, 32'h22, 4'b1011);
        #1;
        chk("bp in_ready stalled", {31'b0, in_ready}, 32'd0);
        tick();
        chk("bp z2 holds", z2, 32'h11);
        tick();
        out_ready = 4'hF;
        #1;
        chk("bp in_ready refill", {31'b0, in_ready}, 32'd1);
        tick();
        set_in(1'b0, 1'b0, 2'd0, 32'h0, 4'hF);
        chk("bp z2 refilled", z2, 32'h22);
        chk("bp beat_cnt", {28'b0, beat_cnt}, 32'd6);
        tick();

        // Round-robin: five beats land on lanes 0,1,2,3,0.
        for (int i = 1; i <= 5; i++) begin
            set_in(1'b1, 1'b1, 2'd3, 32'(i), 4'hF);
            tick();
        end
        set_in(1'b0, 1'b1, 2'd0, 32'h0, 4'hF);
        chk("rr z0", z0, 32'h5);
        chk("rr z1", z1, 32'h2);
        chk("rr z2", z2, 32'h3);
        chk("rr z3", z3, 32'h4);
        chk("rr ptr", {30'b0, rr_ptr}, 32'd1);
        tick();

        // Round-robin stall: lane 1 full and not ready blocks the stream.
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 1'b1, 2'd0, 32'h77 + 32'(i), 4'b1101);
            tick();
        end
        set_in(1'b1, 1'b1, 2'd2, 32'h7B, 4'b1101);
        #1;
        chk("rr stall in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        chk("rr stall ptr", {30'b0, rr_ptr}, 32'd1);
        chk("rr stall z2", z2, 32'h78);
        chk("rr stall z1", z1, 32'h77);
        chk("rr stall out_valid1", {31'b0, out_valid[1]}, 32'd1);
        tick();
        set_in(1'b0, 1'b1, 2'd0, 32'h0, 4'hF);
        tick();

        // Counter wrap with CNT_W=4: 17 beats after reset -> 1.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 17; i++) begin
            set_in(1'b1, 1'b0, 2'($urandom_range(0, 3)), $urandom, 4'hF);
            tick();
        end
        set_in(1'b0, 1'b0, 2'd0, 32'h0, 4'hF);
        chk("wrap beat_cnt", {28'b0, beat_cnt}, 32'd1);
        tick();

        // Fill every lane, then reset mid-operation.
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 1'b0, 2'(i), 32'hC0 + 32'(i), 4'h0);
            tick();
        end
        chk("full out_valid", {28'b0, out_valid}, 32'hF);
        rst_n = 1'b0;
        set_in(1'b1, 1'b0, 2'd1, 32'hEE, 4'h0);
        #1;
        chk("midrst in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        chk("midrst out_valid", {28'b0, out_valid}, 32'd0);
        chk("midrst z1", z1, 32'h0);
        rst_n = 1'b1;
        set_in(1'b0, 1'b0, 2'd0, 32'h0, 4'hF);
        tick();

        // Random traffic: modes, selects, lane stalls and rare resets.
        m_acc = 0;
        for (int c = 0; c < 3000 && m_acc < 500; c++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 15) == 0) rr_mode = ~rr_mode;
            in_valid  = ($urandom_range(0, 9) < 7);
            sel       = 2'($urandom_range(0, 3));
            in_data   = $urandom;
            out_ready = 4'($urandom_range(0, 15));
            tick();
        end
        rst_n = 1'b1;
        set_in(1'b0, 1'b0, 2'd0, 32'h0, 4'hF);
        chk("random beats accepted", (m_acc >= 500) ? 32'd1 : 32'd0, 32'd1);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
